ad7822_reader: RTL and testbench

- Sequencer for one AD7822 8-bit parallel ADC (0–2 V range) on the rectifier board.
- Issues periodic conversion starts and waits for end-of-conversion, then performs the CS/RD read.
- Presents a registered 8-bit sample with a one-cycle valid strobe, directly upstream of the sensing stages (the sample drives their `Ibat_ADC` / `Vbat_ADC` input).
- Instantiate one per ADC: battery current and battery voltage.

---
 rtl/ad7822_reader_pkg.sv | 25 ++
 rtl/ad7822_reader_sync_2ff.sv | 25 ++
 rtl/ad7822_reader.sv | 160 ++++++++++++++++
 tb/tb_ad7822_reader.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad7822_reader_pkg.sv
// Shared definitions for the AD7822 reader: FSM state encodings and default
// timing constants for a 50 MHz clock.
package ad7822_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CONVST   = 3'd1,
    ST_WAIT_EOC = 3'd2,
    ST_READ     = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  localparam int unsigned SAMPLE_PERIOD_DEF = 100;  // 2 us at 50 MHz
  localparam int unsigned CONVST_CYC_DEF    = 2;    // >= 20 ns
  localparam int unsigned RD_CYC_DEF        = 3;    // >= 60 ns access
  localparam int unsigned TIMEOUT_CYC_DEF   = 64;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ad7822_reader_sync_2ff.sv
// Generic two-flop synchronizer for asynchronous board inputs; resets to all ones
// so active-low strobes read as inactive out of reset.
module sync_2ff #(
  parameter int unsigned          WIDTH     = 1,
  parameter logic [WIDTH-1:0]     RESET_VAL = '1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      dout <= RESET_VAL;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/ad7822_reader.sv
// Conversion/read sequencer for one AD7822 8-bit parallel ADC.
// Build option AD7822_READER_AVG_EN: o_data becomes a 4-sample running average.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for a period tick while i_enable is high
// CONVST   | o_CONVST_n held low for CONVST_CYC cycles
// WAIT_EOC | waiting for synchronized EOC_n low, bounded by TIMEOUT_CYC
// READ     | o_CS_n/o_RD_n held low for RD_CYC cycles, data captured last
// DONE     | o_valid high for one cycle with the new o_data
module ad7822_reader
  import ad7822_reader_pkg::*;
#(
  parameter int unsigned SAMPLE_PERIOD = SAMPLE_PERIOD_DEF,
  parameter int unsigned CONVST_CYC    = CONVST_CYC_DEF,
  parameter int unsigned RD_CYC        = RD_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC   = TIMEOUT_CYC_DEF
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic       i_EOC_n,
  input  logic [7:0] i_data,
  output logic       o_CONVST_n,
  output logic       o_CS_n,
  output logic       o_RD_n,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_timeout
);

  localparam int unsigned PER_W   = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned STG_MAX = max3(CONVST_CYC, RD_CYC, TIMEOUT_CYC);
  localparam int unsigned STG_W   = (STG_MAX > 1) ? $clog2(STG_MAX) : 1;

  logic eoc_n_sync;

  sync_2ff #(.WIDTH(1), .RESET_VAL(1'b1)) u_eoc_sync (
    .clock (i_clock),
    .reset (i_reset),
    .din   (i_EOC_n),
    .dout  (eoc_n_sync)
  );

  logic [PER_W-1:0] per_cnt;
  logic             tick;

  assign tick = (per_cnt == PER_W'(SAMPLE_PERIOD - 1));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) per_cnt <= '0;
    else         per_cnt <= tick ? '0 : per_cnt + PER_W'(1);
  end

  state_t           state, state_nxt;
  logic [STG_W-1:0] cnt, cnt_nxt;
  logic             convst_n_nxt, rd_n_nxt, timeout_nxt, valid_nxt, load_sample;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    convst_n_nxt = 1'b1;
    rd_n_nxt     = 1'b1;
    timeout_nxt  = o_timeout;
    valid_nxt    = 1'b0;
    load_sample  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tick && i_enable) begin
          state_nxt    = ST_CONVST;
          cnt_nxt      = '0;
          convst_n_nxt = 1'b0;
        end
      end
      ST_CONVST: begin
        if (cnt == STG_W'(CONVST_CYC - 1)) begin
          state_nxt = ST_WAIT_EOC;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt      = cnt + STG_W'(1);
          convst_n_nxt = 1'b0;
        end
      end
      ST_WAIT_EOC: begin
        if (!eoc_n_sync) begin
          state_nxt = ST_READ;
          cnt_nxt   = '0;
          rd_n_nxt  = 1'b0;
        end else if (cnt == STG_W'(TIMEOUT_CYC - 1)) begin
          state_nxt   = ST_IDLE;
          cnt_nxt     = '0;
          timeout_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + STG_W'(1);
        end
      end
      ST_READ: begin
        // Capture lands straight in the output path so o_valid coincides with DONE.
        if (cnt == STG_W'(RD_CYC - 1)) begin
          state_nxt   = ST_DONE;
          cnt_nxt     = '0;
          load_sample = 1'b1;
          valid_nxt   = 1'b1;
          timeout_nxt = 1'b0;
        end else begin
          cnt_nxt  = cnt + STG_W'(1);
          rd_n_nxt = 1'b0;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      o_CONVST_n <= 1'b1;
      o_CS_n     <= 1'b1;
      o_RD_n     <= 1'b1;
      o_valid    <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      o_CONVST_n <= convst_n_nxt;
      o_CS_n     <= rd_n_nxt;
      o_RD_n     <= rd_n_nxt;
      o_valid    <= valid_nxt;
      o_timeout  <= timeout_nxt;
    end
  end

`ifdef AD7822_READER_AVG_EN
  logic [3:0][7:0] hist;
  logic [9:0]      sum, sum_nxt;

  // sum always contains hist[3], so the subtraction cannot underflow.
  assign sum_nxt = sum + 10'(i_data) - 10'(hist[3]);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      hist   <= '0;
      sum    <= '0;
      o_data <= '0;
    end else if (load_sample) begin
      hist   <= {hist[2:0], i_data};
      sum    <= sum_nxt;
      o_data <= sum_nxt[9:2];
    end
  end
`else
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)          o_data <= '0;
    else if (load_sample) o_data <= i_data;
  end
`endif

endmodule

// File: tb/tb_ad7822_reader.sv
// Self-checking bench for ad7822_reader: directed vectors against a behavioural
// ADC model, plus timeout, enable-drop, reset-abort, fast-period and averaging cases.
module tb_ad7822_reader;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst_main = 1'b1, en_main = 1'b0, eoc_main = 1'b1;
  logic [7:0] data_main = 8'h00;
  logic       convst_main, cs_main, rd_main, valid_main, to_main;
  logic [7:0] odata_main;

  logic       rst_fast = 1'b1, en_fast = 1'b0, eoc_fast = 1'b1;
  logic [7:0] data_fast = 8'hC3;
  logic       convst_f, cs_f, rd_f, valid_f, to_f;
  logic [7:0] odata_f;

  ad7822_reader dut (
    .i_clock(clk), .i_reset(rst_main), .i_enable(en_main), .i_EOC_n(eoc_main),
    .i_data(data_main), .o_CONVST_n(convst_main), .o_CS_n(cs_main), .o_RD_n(rd_main),
    .o_data(odata_main), .o_valid(valid_main), .o_timeout(to_main)
  );

  ad7822_reader #(.SAMPLE_PERIOD(10)) dut_fast (
    .i_clock(clk), .i_reset(rst_fast), .i_enable(en_fast), .i_EOC_n(eoc_fast),
    .i_data(data_fast), .o_CONVST_n(convst_f), .o_CS_n(cs_f), .o_RD_n(rd_f),
    .o_data(odata_f), .o_valid(valid_f), .o_timeout(to_f)
  );

  int n_tests = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc++;

  // ADC model: EOC_n falls eoc_delay_m cycles after CONVST_n rises (0 = at CONVST_n fall),
  // returns high once RD_n goes low.
  int   eoc_delay_m = 10, eoc_dly_m = 0;
  bit   eoc_en_m = 1'b1;
  logic prev_cv_m = 1'b1;
  always @(posedge clk) begin
    #1;
    if (rst_main) begin
      eoc_main  = 1'b1;
      eoc_dly_m = 0;
    end else begin
      if (prev_cv_m && !convst_main && eoc_en_m && eoc_delay_m == 0) eoc_main = 1'b0;
      else if (!prev_cv_m && convst_main && eoc_en_m && eoc_delay_m > 0) eoc_dly_m = eoc_delay_m;
      else if (eoc_dly_m > 0) begin
        eoc_dly_m--;
        if (eoc_dly_m == 0) eoc_main = 1'b0;
      end
      if (!rd_main) eoc_main = 1'b1;
    end
    prev_cv_m = convst_main;
  end

  int   eoc_dly_f = 0;
  logic prev_cv_fm = 1'b1;
  always @(posedge clk) begin
    #1;
    if (rst_fast) begin
      eoc_fast  = 1'b1;
      eoc_dly_f = 0;
    end else begin
      if (!prev_cv_fm && convst_f) eoc_dly_f = 20;
      else if (eoc_dly_f > 0) begin
        eoc_dly_f--;
        if (eoc_dly_f == 0) eoc_fast = 1'b0;
      end
      if (!rd_f) eoc_fast = 1'b1;
    end
    prev_cv_fm = convst_f;
  end

  // Monitors sample on the falling edge.
  logic prev_cv = 1'b1, prev_v = 1'b0, prev_to = 1'b0, prev_cvf = 1'b1, prev_vf = 1'b0;
  int n_cv = 0, cv_cyc = 0, n_val = 0, val_cyc = 0, val_data = 0, val_to = 0;
  int n_to = 0, to_cyc = 0, cv_run = 0, cv_len = 0, rd_run = 0, rd_len = 0;
  int v_run = 0, v_len = 0, n_ovl = 0, n_csrd = 0;
  int n_cv_f = 0, cv_cyc_f = 0, cv_first_f = 0, n_bad_int_f = 0, n_val_f = 0, val_data_f = 0;

  always @(negedge clk) begin
    if (prev_cv && !convst_main) begin n_cv++; cv_cyc = cyc; end
    if (!convst_main) cv_run++; else if (cv_run != 0) begin cv_len = cv_run; cv_run = 0; end
    if (!rd_main) rd_run++; else if (rd_run != 0) begin rd_len = rd_run; rd_run = 0; end
    if (valid_main) begin
      if (!prev_v) begin n_val++; val_cyc = cyc; val_data = int'(odata_main); val_to = int'(to_main); end
      v_run++;
    end else if (v_run != 0) begin v_len = v_run; v_run = 0; end
    if (to_main && !prev_to) begin n_to++; to_cyc = cyc; end
    if (!convst_main && !rd_main) n_ovl++;
    if (!convst_f && !rd_f) n_ovl++;
    if (cs_main != rd_main || cs_f != rd_f) n_csrd++;
    if (prev_cvf && !convst_f) begin
      if (n_cv_f == 0) cv_first_f = cyc;
      else if (cyc - cv_cyc_f != 30) n_bad_int_f++;
      n_cv_f++;
      cv_cyc_f = cyc;
    end
    if (valid_f && !prev_vf) begin n_val_f++; val_data_f = int'(odata_f); end
    prev_cv = convst_main; prev_v = valid_main; prev_to = to_main;
    prev_cvf = convst_f; prev_vf = valid_f;
  end

`ifdef AD7822_READER_AVG_EN
  logic [7:0]  mh [4];
  int unsigned msum;
  function automatic void avg_reset();
    for (int i = 0; i < 4; i++) mh[i] = 8'h00;
    msum = 0;
  endfunction
  function automatic int avg_push(input logic [7:0] x);
    msum = msum + x - mh[3];
    mh[3] = mh[2]; mh[2] = mh[1]; mh[1] = mh[0]; mh[0] = x;
    return int'(msum >> 2);
  endfunction
`endif

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic next_start(input string name, input int exp_gap, input int ref_cyc);
    int c0 = n_cv;
    int k = 0;
    while (n_cv == c0 && k < 200) begin @(posedge clk); k++; end
    if (n_cv == c0) begin
      n_tests++; n_fail++;
      $display("FAIL %s: no CONVST_n fall within %0d cycles", name, k);
    end else check(name, cv_cyc - ref_cyc, exp_gap);
  endtask

  task automatic next_val(input string name, input int exp_lat, input int exp_data);
    int c0 = n_val;
    int k = 0;
    while (n_val == c0 && k < 150) begin @(posedge clk); k++; end
    if (n_val == c0) begin
      n_tests++; n_fail++;
      $display("FAIL %s: no o_valid within %0d cycles", name, k);
    end else begin
      check({name, "_latency"}, val_cyc - cv_cyc, exp_lat);
      check({name, "_data"}, val_data, exp_data);
      check({name, "_timeout_at_valid"}, val_to, 0);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    int         dly;
    logic [7:0] exp_data;
    int         lat;
  } vec_t;

  vec_t vecs [5];
  int   rel, last_fall, exp_d, exp_prev, c0, k;
  int   exp6 [5];

  initial begin
    vecs[0] = '{8'h98, 10, 8'h98, 18};
    vecs[1] = '{8'h00,  1, 8'h00,  9};
    vecs[2] = '{8'hFF, 20, 8'hFF, 28};
    vecs[3] = '{8'h5A,  0, 8'h5A,  6};   // EOC already low on entry to WAIT_EOC
    vecs[4] = '{8'h01, 40, 8'h01, 48};
    exp_prev = 0;
`ifdef AD7822_READER_AVG_EN
    avg_reset();
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_convst_n", int'(convst_main), 1);
    check("reset_cs_n", int'(cs_main), 1);
    check("reset_rd_n", int'(rd_main), 1);
    check("reset_data", int'(odata_main), 0);
    check("reset_valid", int'(valid_main), 0);
    check("reset_timeout", int'(to_main), 0);

    // Table-driven conversions at the default period
    @(negedge clk);
    rst_main = 1'b0;
    en_main  = 1'b1;
    rel      = cyc;
    last_fall = rel;
    for (int i = 0; i < 5; i++) begin
      data_main   = vecs[i].data;
      eoc_delay_m = vecs[i].dly;
      next_start("vec_start_gap", 100, last_fall);
      last_fall = cv_cyc;
      exp_d = int'(vecs[i].exp_data);
`ifdef AD7822_READER_AVG_EN
      exp_d = avg_push(vecs[i].data);
`endif
      next_val("vec", vecs[i].lat, exp_d);
      exp_prev = exp_d;
      repeat (3) @(posedge clk);
      check("vec_convst_len", cv_len, 2);
      check("vec_rd_len", rd_len, 3);
      check("vec_valid_len", v_len, 1);
      #1;
    end

    // EOC never arrives: sticky timeout, data held, no valid
    eoc_en_m = 1'b0;
    c0 = n_val;
    next_start("to_start_gap", 100, last_fall);
    last_fall = cv_cyc;
    k = 0;
    while (n_to == 0 && k < 120) begin @(posedge clk); k++; end
    check("timeout_delay", to_cyc - cv_cyc, 66);
    @(posedge clk); #1;
    check("timeout_sticky", int'(to_main), 1);
    check("timeout_data_kept", int'(odata_main), exp_prev);
    check("timeout_no_valid", n_val - c0, 0);
    eoc_en_m    = 1'b1;
    eoc_delay_m = 10;
    data_main   = 8'h33;
    next_start("after_to_gap", 100, last_fall);
    last_fall = cv_cyc;
    #1;
    check("timeout_held_into_next", int'(to_main), 1);
    exp_d = 8'h33;
`ifdef AD7822_READER_AVG_EN
    exp_d = avg_push(8'h33);
`endif
    next_val("after_to", 18, exp_d);
    #1;
    check("timeout_cleared", int'(to_main), 0);

    // Enable dropped during WAIT_EOC
    data_main = 8'h77;
    next_start("en_drop_gap", 100, last_fall);
    repeat (5) @(posedge clk);
    #1 en_main = 1'b0;
    exp_d = 8'h77;
`ifdef AD7822_READER_AVG_EN
    exp_d = avg_push(8'h77);
`endif
    next_val("en_drop", 18, exp_d);
    c0 = n_cv;
    repeat (250) @(posedge clk);
    check("disabled_no_start", n_cv - c0, 0);
    #1 en_main = 1'b1;

    // Reset asserted during READ
    data_main = 8'h44;
    k = 0;
    do begin @(negedge clk); k++; end while (rd_main !== 1'b0 && k < 250);
    check("reached_read", int'(rd_main), 0);
    #3 rst_main = 1'b1;
    #1;
    check("rst_mid_rd_n", int'(rd_main), 1);
    check("rst_mid_cs_n", int'(cs_main), 1);
    check("rst_mid_convst_n", int'(convst_main), 1);
    check("rst_mid_data", int'(odata_main), 0);
    check("rst_mid_valid", int'(valid_main), 0);
    repeat (2) @(negedge clk);
    rst_main = 1'b0;
    rel = cyc;
    c0 = n_val;
`ifdef AD7822_READER_AVG_EN
    avg_reset();
`endif
    next_start("rst_restart_gap", 100, rel);
    last_fall = cv_cyc;
    exp_d = 8'h44;
`ifdef AD7822_READER_AVG_EN
    exp_d = avg_push(8'h44);
`endif
    next_val("rst_restart", 18, exp_d);
    check("rst_first_valid_count", n_val - c0, 1);

    // Short period: busy-state ticks dropped, one start per completed sequence
    @(negedge clk);
    rst_fast = 1'b0;
    en_fast  = 1'b1;
    rel = cyc;
    repeat (400) @(posedge clk);
    check("fast_first_start", cv_first_f - rel, 10);
    check("fast_bad_intervals", n_bad_int_f, 0);
    check("fast_starts", n_cv_f, 13);
    check("fast_valids", n_val_f, 13);
    check("fast_data", val_data_f, 8'hC3);
    #1;
    check("fast_no_timeout", int'(to_f), 0);
    rst_fast = 1'b1;

`ifdef AD7822_READER_AVG_EN
    // Averaging ramp from a cleared history
    exp6[0] = 8'h20; exp6[1] = 8'h40; exp6[2] = 8'h60; exp6[3] = 8'h80; exp6[4] = 8'h80;
    @(negedge clk);
    rst_main = 1'b1;
    @(negedge clk);
    rst_main    = 1'b0;
    rel         = cyc;
    last_fall   = rel;
    data_main   = 8'h80;
    eoc_delay_m = 10;
    for (int i = 0; i < 5; i++) begin
      next_start("avg_start_gap", 100, last_fall);
      last_fall = cv_cyc;
      next_val("avg", 18, exp6[i]);
    end
`endif

    check("strobe_overlap", n_ovl, 0);
    check("cs_rd_split", n_csrd, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #(20 * 20000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

endmodule
